// File: rtl/boton_pkg.sv
// Shared definitions for the multi-channel button conditioner.
// Optional feature macro: BOTON_REPEAT_EN (auto-repeat of long_pulse while held).
package boton_pkg;

   // Press classification states, one instance per channel
   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      HELD
   } press_state_e;

   // Default timing constants (in clock cycles) for a 50 MHz board clock
   localparam int DEF_TIME_ANTIREBOTE = 5000;
   localparam int DEF_MIN_TIME        = 25000000;
   localparam int DEF_REPEAT_TIME     = 5000000;

   // Maps a raw key level onto the internal "pressed = 1" convention
   function automatic logic toPressed(input logic raw, input bit activeLow);
      return activeLow ? ~raw : raw;
   endfunction

   // True when a timing set is usable: the debounce window needs at least two
   // cycles, a long press must outlast the debounce, and the repeat period
   // needs at least two cycles
   function automatic bit paramsValid(input int tAntirebote, input int minTime,
                                      input int repeatTime);
      return (tAntirebote >= 2) && (minTime > tAntirebote) && (repeatTime >= 2);
   endfunction

endpackage

// File: rtl/boton_canal.sv
// One button channel: two-flop synchroniser, debounce counter and the
// short/long press classifier.
// Optional feature macro: BOTON_REPEAT_EN (adds the HELD repeat counter).
module boton_canal
   import boton_pkg::*;
#(
   parameter int TIME_ANTIREBOTE = DEF_TIME_ANTIREBOTE,
   parameter int MIN_TIME        = DEF_MIN_TIME,
   parameter int ACTIVE_LOW      = 1
`ifdef BOTON_REPEAT_EN
   ,
   parameter int REPEAT_TIME     = DEF_REPEAT_TIME
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic boton_i,
   output logic level_o,
   output logic press_o,
   output logic long_o
);

   localparam int DW = $clog2(TIME_ANTIREBOTE + 1);
   localparam int HW = $clog2(MIN_TIME + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(TIME_ANTIREBOTE - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_TIME);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

`ifdef BOTON_REPEAT_EN
   localparam int RW = $clog2(REPEAT_TIME + 1);
   localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_TIME);
`endif

   logic sync1_q;
   logic sync2_q;

   logic [DW-1:0] debCnt_q, debCnt_d;
   logic          level_q, level_d;

   press_state_e  state_q, state_d;
   logic [HW-1:0] hold_q, hold_d, holdInc;
   logic          press_q, press_d;
   logic          long_q, long_d;

`ifdef BOTON_REPEAT_EN
   logic [RW-1:0] rep_q, rep_d, repInc;
`endif

   // Two-flop synchroniser; the raw key is folded to pressed = 1 before it
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= toPressed(boton_i, ACTIVE_LOW != 0);
         sync2_q <= sync1_q;
      end
   end

   // Debounce: the stable level only flips after the sample has disagreed
   // with it for a full window; any agreement restarts the window
   always_comb begin
      debCnt_d = debCnt_q;
      level_d  = level_q;
      if (sync2_q == level_q) begin
         debCnt_d = '0;
      end else if (debCnt_q >= DEB_LAST) begin
         level_d  = ~level_q;
         debCnt_d = '0;
      end else begin
         debCnt_d = debCnt_q + 1'b1;
      end
   end

   // Debounce state register
   always_ff @(posedge clk) begin
      if (reset) begin
         debCnt_q <= '0;
         level_q  <= 1'b0;
      end else begin
         debCnt_q <= debCnt_d;
         level_q  <= level_d;
      end
   end

   // Press classifier next state: level_q is the level of the cycle just
   // ending and level_d the one about to start, so a threshold hit is only
   // honoured when the level is still high afterwards (release wins a tie)
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      press_d = 1'b0;
      long_d  = 1'b0;
      holdInc = (hold_q < HOLD_MAX) ? hold_q + 1'b1 : hold_q;
`ifdef BOTON_REPEAT_EN
      rep_d   = rep_q;
      repInc  = (rep_q < REP_MAX) ? rep_q + 1'b1 : rep_q;
`endif
      case (state_q)
         IDLE: begin
            hold_d = '0;
            if (level_q) begin
               state_d = PRESSED;
               hold_d  = HOLD_ONE;
            end
         end
         PRESSED: begin
            if (!level_q) begin
               press_d = 1'b1;
               state_d = IDLE;
               hold_d  = '0;
            end else begin
               hold_d = holdInc;
               if ((holdInc == HOLD_MAX) && level_d) begin
                  long_d  = 1'b1;
                  state_d = HELD;
`ifdef BOTON_REPEAT_EN
                  rep_d   = '0;
`endif
               end
            end
         end
         HELD: begin
            if (!level_q) begin
               state_d = IDLE;
               hold_d  = '0;
`ifdef BOTON_REPEAT_EN
               rep_d   = '0;
            end else if (repInc == REP_MAX) begin
               rep_d  = '0;
               long_d = level_d;
            end else begin
               rep_d = repInc;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase
   end

   // Press classifier state and registered event outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         press_q <= 1'b0;
         long_q  <= 1'b0;
`ifdef BOTON_REPEAT_EN
         rep_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         press_q <= press_d;
         long_q  <= long_d;
`ifdef BOTON_REPEAT_EN
         rep_q   <= rep_d;
`endif
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;
   assign long_o  = long_q;

endmodule

// File: rtl/boton_multi.sv
// N-channel button conditioner: one boton_canal per raw key, bit i of every
// output belongs to boton_in[i].
// Optional feature macro: BOTON_REPEAT_EN (long_pulse repeats while held).
module boton_multi
   import boton_pkg::*;
#(
   parameter int N_BOTONES       = 4,
   parameter int TIME_ANTIREBOTE = DEF_TIME_ANTIREBOTE,
   parameter int MIN_TIME        = DEF_MIN_TIME,
   parameter int REPEAT_TIME     = DEF_REPEAT_TIME,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_BOTONES-1:0] boton_in,
   output logic [N_BOTONES-1:0] boton_level,
   output logic [N_BOTONES-1:0] press_pulse,
   output logic [N_BOTONES-1:0] long_pulse
);

   // An unusable timing set leaves this marker scope in the elaborated
   // hierarchy so it is easy to spot when browsing a netlist
   if (!paramsValid(TIME_ANTIREBOTE, MIN_TIME, REPEAT_TIME)) begin : gInvalidParameters
   end

   // One fully independent conditioner per key
   for (genvar g = 0; g < N_BOTONES; g++) begin : gCanal
      boton_canal #(
         .TIME_ANTIREBOTE(TIME_ANTIREBOTE),
         .MIN_TIME       (MIN_TIME),
         .ACTIVE_LOW     (ACTIVE_LOW)
`ifdef BOTON_REPEAT_EN
         ,
         .REPEAT_TIME    (REPEAT_TIME)
`endif
      ) uCanal (
         .clk    (clk),
         .reset  (reset),
         .boton_i(boton_in[g]),
         .level_o(boton_level[g]),
         .press_o(press_pulse[g]),
         .long_o (long_pulse[g])
      );
   end

endmodule

// File: tb/tb_boton_multi.sv
// Self-checking bench for boton_multi with small timing constants.
// Honours BOTON_REPEAT_EN when it is defined for the build.
module tb_boton_multi;

   localparam int N = 2;
   localparam int T = 4;
   localparam int M = 20;
   localparam int R = 8;

`ifdef BOTON_REPEAT_EN
   localparam int LONG_40 = 3;
   localparam int LONG_30 = 2;
`else
   localparam int LONG_40 = 1;
   localparam int LONG_30 = 1;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] boton_in;
   logic [N-1:0] boton_level;
   logic [N-1:0] press_pulse;
   logic [N-1:0] long_pulse;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Behavioural model state (pressed = 1), indexed by channel
   int p1[N], p2[N], diff[N];
   int lvlC[N], lvlM1[N], lvlM2[N];
   int runC[N], runM1[N], runM2[N];
   logic [N-1:0] mLevel = '0, mPress = '0, mLong = '0;

   // Observed-output statistics used by the literal checks
   int   pressCnt[N], longCnt[N], highCyc[N];
   int   riseCyc[N], fallCyc[N], pressCyc[N], firstLongCyc[N];
   int   pressBase[N], longBase[N], highBase[N];
   logic [N-1:0] prevLvl = '0;

   always #5 clk = ~clk;

   boton_multi #(
      .N_BOTONES      (N),
      .TIME_ANTIREBOTE(T),
      .MIN_TIME       (M),
      .REPEAT_TIME    (R),
      .ACTIVE_LOW     (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .boton_in   (boton_in),
      .boton_level(boton_level),
      .press_pulse(press_pulse),
      .long_pulse (long_pulse)
   );

   // A press that has been high for 'run' cycles is due a long event now
   function automatic bit longDue(input int run);
      if (run == M) return 1'b1;
`ifdef BOTON_REPEAT_EN
      if (run > M && ((run - M) % R) == 0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Drive a raw vector for n clock periods, changing on the falling edge
   task automatic applyStimulus(input logic [N-1:0] v, input int n);
      @(negedge clk);
      boton_in = v;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic snap();
      for (int i = 0; i < N; i++) begin
         pressBase[i] = pressCnt[i];
         longBase[i]  = longCnt[i];
         highBase[i]  = highCyc[i];
      end
   endtask

   // Model: level follows the synchronised sample once it has disagreed for
   // T consecutive cycles; events are derived from the run length of highs
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            p1[i] = 0; p2[i] = 0; diff[i] = 0;
            lvlC[i] = 0; lvlM1[i] = 0; lvlM2[i] = 0;
            runC[i] = 0; runM1[i] = 0; runM2[i] = 0;
         end
         mLevel = '0;
         mPress = '0;
         mLong  = '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            int sOld;
            sOld  = p2[i];
            p2[i] = p1[i];
            p1[i] = boton_in[i] ? 0 : 1;
            lvlM2[i] = lvlM1[i];
            runM2[i] = runM1[i];
            lvlM1[i] = lvlC[i];
            runM1[i] = runC[i];
            if (sOld != lvlM1[i]) diff[i]++;
            else diff[i] = 0;
            if (diff[i] == T) begin
               lvlC[i] = 1 - lvlC[i];
               diff[i] = 0;
            end
            runC[i]   = (lvlC[i] != 0) ? runM1[i] + 1 : 0;
            mLevel[i] = (lvlC[i] != 0);
            mLong[i]  = (lvlC[i] != 0) && longDue(runM1[i]);
            mPress[i] = (lvlM1[i] == 0) && (lvlM2[i] != 0) &&
                        (runM2[i] >= 1) && (runM2[i] <= M);
         end
      end
   end

   // Compare process: every cycle, 1 time unit after the active edge
   always @(posedge clk) begin
      #1;
      cyc++;
      checkOutput("boton_level", 32'(boton_level), 32'(mLevel));
      checkOutput("press_pulse", 32'(press_pulse), 32'(mPress));
      checkOutput("long_pulse",  32'(long_pulse),  32'(mLong));
      for (int i = 0; i < N; i++) begin
         if (boton_level[i] === 1'b1 && prevLvl[i] !== 1'b1) begin
            riseCyc[i]      = cyc;
            firstLongCyc[i] = -1;
         end
         if (boton_level[i] !== 1'b1 && prevLvl[i] === 1'b1) fallCyc[i] = cyc;
         if (boton_level[i] === 1'b1) highCyc[i]++;
         if (press_pulse[i] === 1'b1) begin
            pressCnt[i]++;
            pressCyc[i] = cyc;
         end
         if (long_pulse[i] === 1'b1) begin
            longCnt[i]++;
            if (firstLongCyc[i] == -1) firstLongCyc[i] = cyc;
         end
      end
      prevLvl = boton_level;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int relCyc;
      reset    = 1'b1;
      boton_in = 2'b00;
      for (int i = 0; i < N; i++) begin
         pressCnt[i] = 0; longCnt[i] = 0; highCyc[i] = 0;
         riseCyc[i] = 0; fallCyc[i] = 0; pressCyc[i] = 0; firstLongCyc[i] = -1;
      end

      // Reset held three cycles with both keys pressed
      repeat (3) @(negedge clk);
      checkOutput("rst.level", 32'(boton_level), 32'd0);
      checkOutput("rst.press", 32'(press_pulse), 32'd0);
      checkOutput("rst.long",  32'(long_pulse),  32'd0);
      reset = 1'b0;
      n = 0;
      while (n < 50) begin
         @(posedge clk);
         #1;
         n++;
         if (boton_level === 2'b11) break;
      end
      checkOutput("rst.levelDelay", 32'(n), 32'd6);
      applyStimulus(2'b11, 14);

      // Bounce on channel 0 never reaches a full debounce window
      snap();
      applyStimulus(2'b10, 3);
      applyStimulus(2'b11, 1);
      applyStimulus(2'b10, 2);
      applyStimulus(2'b11, 14);
      checkOutput("bounce.high0",  32'(highCyc[0] - highBase[0]),   32'd0);
      checkOutput("bounce.press0", 32'(pressCnt[0] - pressBase[0]), 32'd0);
      checkOutput("bounce.long0",  32'(longCnt[0] - longBase[0]),   32'd0);

      // Short press on channel 0
      snap();
      applyStimulus(2'b10, 10);
      applyStimulus(2'b11, 14);
      checkOutput("short.high0",  32'(highCyc[0] - highBase[0]),   32'd10);
      checkOutput("short.press0", 32'(pressCnt[0] - pressBase[0]), 32'd1);
      checkOutput("short.long0",  32'(longCnt[0] - longBase[0]),   32'd0);
      checkOutput("short.pressLag", 32'(pressCyc[0] - fallCyc[0]), 32'd1);

      // Long press on channel 1
      snap();
      applyStimulus(2'b01, 40);
      applyStimulus(2'b11, 16);
      checkOutput("long.high1",  32'(highCyc[1] - highBase[1]),   32'd40);
      checkOutput("long.long1",  32'(longCnt[1] - longBase[1]),   32'(LONG_40));
      checkOutput("long.press1", 32'(pressCnt[1] - pressBase[1]), 32'd0);
      checkOutput("long.lag1",   32'(firstLongCyc[1] - riseCyc[1]), 32'd20);

      // Release coincides with the threshold: short press wins
      snap();
      applyStimulus(2'b10, 20);
      applyStimulus(2'b11, 14);
      checkOutput("bound.high0",  32'(highCyc[0] - highBase[0]),   32'd20);
      checkOutput("bound.press0", 32'(pressCnt[0] - pressBase[0]), 32'd1);
      checkOutput("bound.long0",  32'(longCnt[0] - longBase[0]),   32'd0);

      // Independence: 8-cycle press on channel 0, 30-cycle press on channel 1
      snap();
      applyStimulus(2'b00, 8);
      applyStimulus(2'b01, 22);
      applyStimulus(2'b11, 16);
      checkOutput("indep.press0", 32'(pressCnt[0] - pressBase[0]), 32'd1);
      checkOutput("indep.long0",  32'(longCnt[0] - longBase[0]),   32'd0);
      checkOutput("indep.press1", 32'(pressCnt[1] - pressBase[1]), 32'd0);
      checkOutput("indep.long1",  32'(longCnt[1] - longBase[1]),   32'(LONG_30));

      // Reset in the middle of a press, key still held afterwards
      snap();
      applyStimulus(2'b10, 10);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("midrst.level", 32'(boton_level), 32'd0);
      checkOutput("midrst.press", 32'(press_pulse), 32'd0);
      reset  = 1'b0;
      relCyc = cyc;
      applyStimulus(2'b10, 12);
      applyStimulus(2'b11, 14);
      checkOutput("midrst.rise0",  32'(riseCyc[0] - relCyc), 32'd6);
      checkOutput("midrst.press0", 32'(pressCnt[0] - pressBase[0]), 32'd1);

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
